gate_identifier: RTL and testbench

GATE_IDENTIFIER -- requirements
Module: gate_identifier

---
 rtl/gate_pkg.sv | 27 ++
 rtl/gate_decode.sv | 23 ++
 rtl/gate_identifier.sv | 114 +++++++++++
 tb/tb_gate_identifier.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared types and constants for the 2-input gate identifier.
package gate_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned TT_W   = 4;
    localparam int unsigned GATE_W = 3;

    typedef logic [GATE_W-1:0] gate_code_t;

    localparam gate_code_t GATE_AND     = 3'd0;
    localparam gate_code_t GATE_OR      = 3'd1;
    localparam gate_code_t GATE_NAND    = 3'd2;
    localparam gate_code_t GATE_NOR     = 3'd3;
    localparam gate_code_t GATE_XOR     = 3'd4;
    localparam gate_code_t GATE_XNOR    = 3'd5;
    localparam gate_code_t GATE_NOT_IN1 = 3'd6;
    localparam gate_code_t GATE_OTHER   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DECODE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gate_decode.sv
// Combinational mapping from a captured truth table (bit index = {in1,in2}) to a gate code.
module gate_decode
    import gate_pkg::*;
(
    input  logic [TT_W-1:0] truth,
    output gate_code_t      gate_id
);

    always_comb begin
        gate_id = GATE_OTHER;
        case (truth)
            4'b1000: gate_id = GATE_AND;
            4'b1110: gate_id = GATE_OR;
            4'b0111: gate_id = GATE_NAND;
            4'b0001: gate_id = GATE_NOR;
            4'b0110: gate_id = GATE_XOR;
            4'b1001: gate_id = GATE_XNOR;
            4'b0011: gate_id = GATE_NOT_IN1;
            default: gate_id = GATE_OTHER;
        endcase
    end

endmodule

// File: rtl/gate_identifier.sv
// Walks a 2-input gate through all four input vectors, captures its truth table
// and reports which standard gate it implements.
module gate_identifier
    import gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            dut_in1,
    output logic            dut_in2,
    input  logic            dut_out1,
    output logic [TT_W-1:0] truth,
    output gate_code_t      gate_id
);

    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [TT_W-1:0]   truth_nxt;
    gate_code_t        gate_id_nxt, decoded_c;
    logic              busy_nxt, done_nxt, in1_nxt, in2_nxt;

    gate_decode u_decode (
        .truth   (truth),
        .gate_id (decoded_c)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            truth   <= '0;
            gate_id <= GATE_OTHER;
            busy    <= 1'b0;
            done    <= 1'b0;
            dut_in1 <= 1'b0;
            dut_in2 <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            truth   <= truth_nxt;
            gate_id <= gate_id_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            dut_in1 <= in1_nxt;
            dut_in2 <= in2_nxt;
        end
    end

    // Next-state logic; outputs are computed for the cycle after the edge
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        truth_nxt   = truth;
        gate_id_nxt = gate_id;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        in1_nxt     = 1'b0;
        in2_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = SETTLE;
                    idx_nxt   = '0;
                    truth_nxt = '0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_DRIVE: begin
                busy_nxt           = 1'b1;
                {in1_nxt, in2_nxt} = idx;
                if (cnt == '0) begin
                    // Last hold cycle of this vector: capture, then advance
                    truth_nxt[idx] = dut_out1;
                    if (idx == 2'd3) begin
                        state_nxt          = ST_DECODE;
                        idx_nxt            = '0;
                        {in1_nxt, in2_nxt} = 2'b00;
                    end else begin
                        idx_nxt            = idx + 2'd1;
                        cnt_nxt            = SETTLE;
                        {in1_nxt, in2_nxt} = idx + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_DECODE: begin
                gate_id_nxt = decoded_c;
                done_nxt    = 1'b1;
                state_nxt   = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_identifier.sv
// Bench for gate_identifier: bench-side gate models, default and zero-settle instances.
module tb_gate_identifier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b;
    logic       busy_a, done_a, in1_a, in2_a, out_a;
    logic       busy_b, done_b, in1_b, in2_b, out_b;
    logic [3:0] truth_a, truth_b;
    logic [2:0] gid_a, gid_b;
    logic [3:0] tt;
    logic       sel;

    int vectors     = 0;
    int miscompares = 0;

    // Gate under test is modelled as a lookup on whatever the DUT drives
    assign out_a = tt[{in1_a, in2_a}];
    assign out_b = tt[{in1_b, in2_b}];

    logic       busy_m, done_m, in1_m, in2_m;
    logic [3:0] truth_m;
    logic [2:0] gid_m;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign done_m  = sel ? done_b  : done_a;
    assign in1_m   = sel ? in1_b   : in1_a;
    assign in2_m   = sel ? in2_b   : in2_a;
    assign truth_m = sel ? truth_b : truth_a;
    assign gid_m   = sel ? gid_b   : gid_a;

    gate_identifier #(.SETTLE_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .dut_in1(in1_a), .dut_in2(in2_a), .dut_out1(out_a),
        .truth(truth_a), .gate_id(gid_a)
    );

    gate_identifier #(.SETTLE_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .dut_in1(in1_b), .dut_in2(in2_b), .dut_out1(out_b),
        .truth(truth_b), .gate_id(gid_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: evaluate each named boolean function on all four input pairs
    function automatic logic [2:0] ref_id(input logic [3:0] t);
        logic [3:0] row;
        logic       a, b, f;
        for (int g = 0; g < 7; g++) begin
            for (int i = 0; i < 4; i++) begin
                a = (i / 2) != 0;
                b = (i % 2) != 0;
                case (g)
                    0:       f = a & b;
                    1:       f = a | b;
                    2:       f = ~(a & b);
                    3:       f = ~(a | b);
                    4:       f = a ^ b;
                    5:       f = ~(a ^ b);
                    default: f = ~a;
                endcase
                row[i] = f;
            end
            if (row == t) return 3'(g);
        end
        return 3'd7;
    endfunction

    task automatic drive_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // One run; checks every cycle from T+1 through the first idle cycle after done
    task automatic run(input logic [3:0] t, input int pulse_k, input bit done_pulse);
        int p;
        int last;
        p    = sel ? 1 : 3;
        last = 4 * p + 3;
        tt   = t;
        drive_start(1'b1);
        @(negedge clk);
        for (int k = 1; k <= last; k++) begin
            if (k == 1) chk("truth_clear", 8'(truth_m), 8'h0);
            if (k <= 4 * p) begin
                chk("busy_drive", 8'(busy_m), 8'h1);
                chk("done_drive", 8'(done_m), 8'h0);
                chk("vector", 8'({in1_m, in2_m}), 8'((k - 1) / p));
            end else if (k == 4 * p + 1) begin
                chk("busy_decode", 8'(busy_m), 8'h1);
                chk("done_decode", 8'(done_m), 8'h0);
                chk("vector_decode", 8'({in1_m, in2_m}), 8'h0);
            end else if (k == 4 * p + 2) begin
                chk("done_pulse", 8'(done_m), 8'h1);
                chk("busy_done", 8'(busy_m), 8'h0);
                chk("truth", 8'(truth_m), 8'(t));
                chk("gate_id", 8'(gid_m), 8'(ref_id(t)));
            end else begin
                chk("done_after", 8'(done_m), 8'h0);
                chk("busy_after", 8'(busy_m), 8'h0);
                chk("truth_hold", 8'(truth_m), 8'(t));
                chk("gate_id_hold", 8'(gid_m), 8'(ref_id(t)));
            end
            drive_start(k == pulse_k || (done_pulse && k == 4 * p + 2));
            if (k < last) @(negedge clk);
        end
        if (done_pulse) begin
            @(negedge clk);
            chk("busy_ignored", 8'(busy_m), 8'h0);
            chk("done_ignored", 8'(done_m), 8'h0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},  8'(busy_m),  8'h0);
        chk({tag, "_done"},  8'(done_m),  8'h0);
        chk({tag, "_dut"},   8'({in1_m, in2_m}), 8'h0);
        chk({tag, "_truth"}, 8'(truth_m), 8'h0);
        chk({tag, "_gid"},   8'(gid_m),   8'h7);
    endtask

    initial begin
        logic seen_done;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sel     = 1'b0;
        tt      = 4'b0000;
        repeat (3) @(negedge clk);
        check_reset_state("rst_a");
        sel = 1'b1;
        check_reset_state("rst_b");
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed runs on the default-settle instance
        run(4'b1000, 5, 1'b0);
        run(4'b0110, 0, 1'b0);
        run(4'b1001, 0, 1'b1);
        run(4'b0000, 0, 1'b0);
        run(4'b0011, 0, 1'b0);
        run(4'b1110, 0, 1'b0);
        run(4'b0001, 0, 1'b0);
        run(4'b0111, 0, 1'b0);

        // Reset during a run aborts with no done
        tt      = 4'b1000;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk("busy_pre_rst", 8'(busy_a), 8'h1);
            if (k == 7) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        check_reset_state("mid_rst");
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_done = seen_done | done_a | busy_a;
        end
        chk("no_done_after_rst", 8'(seen_done), 8'h0);
        run(4'b1000, 0, 1'b0);

        for (int r = 0; r < 25; r++)
            run(4'($urandom), int'($urandom_range(0, 14)), 1'($urandom));

        // Zero-settle instance
        @(negedge clk);
        sel = 1'b1;
        run(4'b0111, 0, 1'b0);
        for (int r = 0; r < 12; r++)
            run(4'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
        drive_start(1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
